// File: rtl/coin_acceptor_pkg.sv
// Shared constants and types for the coin acceptor front end and its
// downstream consumers (vending FSM, scoreboards).
package coin_acceptor_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

   localparam int COIN5_VALUE  = 5;
   localparam int COIN10_VALUE = 10;

   typedef enum logic [1:0] {
      ISSUE_NONE,
      ISSUE_COIN5,
      ISSUE_COIN10,
      ISSUE_REJECT
   } issue_e;

endpackage

// File: rtl/coin_acceptor_if.sv
// Raw sensor inputs, accept enable and the clean coin pulses of the acceptor.
interface coin_acceptor_if;

   logic raw_coin5;
   logic raw_coin10;
   logic accept_en;
   logic coin5;
   logic coin10;
   logic coin_reject;

   modport master (
      output raw_coin5, raw_coin10, accept_en,
      input  coin5, coin10, coin_reject
   );

   modport slave (
      input  raw_coin5, raw_coin10, accept_en,
      output coin5, coin10, coin_reject
   );

endinterface

// File: rtl/coin_debounce.sv
// One coin slot channel: 2-flop synchronizer, stability counter and a
// rising-edge strobe on the debounced level.
module coin_debounce
   import coin_acceptor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             deb_q, deb_d;
   logic             deb_prev_q, deb_prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any sample agreeing with the current level restarts the stability count.
   always_comb begin
      s1_d       = raw;
      s2_d       = s1_q;
      deb_d      = deb_q;
      deb_prev_d = deb_q;
      cnt_d      = cnt_q;
      if (s2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         deb_d = s2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Debounced level resets high so a slot already held at reset release stays silent.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         deb_q      <= 1'b1;
         deb_prev_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         cnt_q      <= cnt_d;
      end
   end

   assign rise = deb_q & ~deb_prev_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin slot front end: debounces both slots, queues one pending coin per slot
// and issues at most one registered pulse per cycle, 10-unit coins first.
module coin_acceptor
   import coin_acceptor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic            clk,
   input  logic            reset,
   coin_acceptor_if.slave  bus
);

   logic   rise5;
   logic   rise10;
   logic   pend5_q, pend5_d;
   logic   pend10_q, pend10_d;
   logic   coin5_q, coin5_d;
   logic   coin10_q, coin10_d;
   logic   coin_reject_q, coin_reject_d;
   logic   take5;
   logic   take10;
   issue_e issue;

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.raw_coin5),
      .rise  (rise5)
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.raw_coin10),
      .rise  (rise10)
   );

   // A coin is issued or rejected in the same cycle its pending flag clears.
   always_comb begin
      take10 = pend10_q;
      take5  = pend5_q & ~pend10_q;
      issue  = ISSUE_NONE;
      if (take10 || take5) begin
         if (!bus.accept_en) begin
            issue = ISSUE_REJECT;
         end else if (take10) begin
            issue = ISSUE_COIN10;
         end else begin
            issue = ISSUE_COIN5;
         end
      end
      pend10_d      = (pend10_q & ~take10) | rise10;
      pend5_d       = (pend5_q & ~take5) | rise5;
      coin10_d      = (issue == ISSUE_COIN10);
      coin5_d       = (issue == ISSUE_COIN5);
      coin_reject_d = (issue == ISSUE_REJECT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend5_q       <= 1'b0;
         pend10_q      <= 1'b0;
         coin5_q       <= 1'b0;
         coin10_q      <= 1'b0;
         coin_reject_q <= 1'b0;
      end else begin
         pend5_q       <= pend5_d;
         pend10_q      <= pend10_d;
         coin5_q       <= coin5_d;
         coin10_q      <= coin10_d;
         coin_reject_q <= coin_reject_d;
      end
   end

   assign bus.coin5       = coin5_q;
   assign bus.coin10      = coin10_q;
   assign bus.coin_reject = coin_reject_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a run-length/stage-delay model checked
// every cycle, plus hand-computed pulse counts and latencies per scenario.
module tb_coin_acceptor;
   import coin_acceptor_pkg::*;

   localparam int D = DEFAULT_DEBOUNCE_CYCLES;

   logic clk = 1'b0;
   logic reset = 1'b1;

   coin_acceptor_if bus ();

   coin_acceptor #(.DEBOUNCE_CYCLES(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_no = 0;

   // Model state, index 0 = 5-unit slot, index 1 = 10-unit slot.
   logic [1:0] m_d1, m_d2, m_last, m_deb, m_rise, m_pend;
   int         m_run [2];
   logic       exp5, exp10, exprej;
   bit         model_valid = 0;

   int n5 = 0, n10 = 0, nrej = 0;
   int last5 = -1, last10 = -1, lastrej = -1;
   int total_value = 0;

   // A debounced level flips once the synchronized sample has held the new
   // value for D edges; the coin is pending one edge later and issued the next.
   always @(posedge clk) begin
      logic [1:0] raw_now;
      int         taken;
      edge_no++;
      raw_now = {bus.raw_coin10, bus.raw_coin5};
      if (reset) begin
         m_d1 = '0; m_d2 = '0; m_last = 2'b11; m_deb = 2'b11;
         m_rise = '0; m_pend = '0;
         m_run[0] = 0; m_run[1] = 0;
         exp5 = 0; exp10 = 0; exprej = 0;
         model_valid = 1;
      end else begin
         exp5 = 0; exp10 = 0; exprej = 0;
         taken = m_pend[1] ? 1 : (m_pend[0] ? 0 : -1);
         if (taken >= 0) begin
            if (!bus.accept_en) exprej = 1;
            else if (taken == 1) exp10 = 1;
            else exp5 = 1;
            m_pend[taken] = 1'b0;
         end
         for (int c = 0; c < 2; c++) begin
            if (m_rise[c]) begin
               if (m_pend[c]) begin
                  errors++;
                  $display("[TB] FAIL coalesce ch%0d at edge %0d: got new event while pending, required none", c, edge_no);
               end
               m_pend[c] = 1'b1;
            end
         end
         for (int c = 0; c < 2; c++) begin
            if (m_d2[c] == m_last[c]) m_run[c]++;
            else begin
               m_run[c] = 1;
               m_last[c] = m_d2[c];
            end
            m_rise[c] = 1'b0;
            if (m_d2[c] != m_deb[c] && m_run[c] >= D) begin
               m_rise[c] = m_d2[c];
               m_deb[c]  = m_d2[c];
            end
         end
         m_d2 = m_d1;
         m_d1 = raw_now;
      end
   end

   // Compare on the falling edge, away from register updates.
   always @(negedge clk) begin
      if (model_valid) begin
         checks++;
         if ({bus.coin10, bus.coin5, bus.coin_reject} !== {exp10, exp5, exprej}) begin
            errors++;
            $display("[TB] FAIL outputs edge %0d: got c10=%b c5=%b rej=%b, required c10=%b c5=%b rej=%b",
                     edge_no, bus.coin10, bus.coin5, bus.coin_reject, exp10, exp5, exprej);
         end
         checks++;
         if (int'(bus.coin10 === 1'b1) + int'(bus.coin5 === 1'b1) + int'(bus.coin_reject === 1'b1) > 1) begin
            errors++;
            $display("[TB] FAIL exclusive edge %0d: got c10=%b c5=%b rej=%b, required at most one high",
                     edge_no, bus.coin10, bus.coin5, bus.coin_reject);
         end
         if (bus.coin5 === 1'b1) begin n5++; last5 = edge_no; total_value += COIN5_VALUE; end
         if (bus.coin10 === 1'b1) begin n10++; last10 = edge_no; total_value += COIN10_VALUE; end
         if (bus.coin_reject === 1'b1) begin nrej++; lastrej = edge_no; end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic apply_stimulus(input logic r5, input logic r10, input logic acc, input int cycles);
      bus.raw_coin5  = r5;
      bus.raw_coin10 = r10;
      bus.accept_en  = acc;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic check_output(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   int b5, b10, brej, e0;

   task automatic snapshot();
      b5 = n5; b10 = n10; brej = nrej;
   endtask

   initial begin
      bus.raw_coin5  = 1'b0;
      bus.raw_coin10 = 1'b0;
      bus.accept_en  = 1'b1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_output("reset_coin5", int'(bus.coin5), 0);
      check_output("reset_coin10", int'(bus.coin10), 0);
      check_output("reset_reject", int'(bus.coin_reject), 0);
      reset = 1'b0;
      apply_stimulus(0, 0, 1, 10);
      check_output("idle_pulses", n5 + n10 + nrej, 0);

      $display("[TB] scenario 1: single 5-unit coin");
      snapshot(); e0 = edge_no + 1;
      apply_stimulus(1, 0, 1, 12);
      check_output("t1_coin5_count", n5 - b5, 1);
      check_output("t1_coin5_edge", last5 - e0, 7);
      check_output("t1_others", (n10 - b10) + (nrej - brej), 0);
      apply_stimulus(0, 0, 1, 12);

      $display("[TB] scenario 2: bouncy 10-unit coin");
      snapshot();
      apply_stimulus(0, 1, 1, 1);
      apply_stimulus(0, 0, 1, 1);
      apply_stimulus(0, 1, 1, 2);
      apply_stimulus(0, 0, 1, 1);
      e0 = edge_no + 1;
      apply_stimulus(0, 1, 1, 12);
      check_output("t2_coin10_count", n10 - b10, 1);
      check_output("t2_coin10_edge", last10 - e0, 7);
      apply_stimulus(0, 0, 1, 12);

      $display("[TB] scenario 3: simultaneous coins");
      snapshot(); e0 = edge_no + 1;
      apply_stimulus(1, 1, 1, 12);
      check_output("t3_coin10_count", n10 - b10, 1);
      check_output("t3_coin5_count", n5 - b5, 1);
      check_output("t3_coin10_edge", last10 - e0, 7);
      check_output("t3_coin5_edge", last5 - e0, 8);
      apply_stimulus(0, 0, 1, 12);

      $display("[TB] scenario 4: reject then accept");
      snapshot(); e0 = edge_no + 1;
      apply_stimulus(0, 1, 0, 12);
      check_output("t4_reject_count", nrej - brej, 1);
      check_output("t4_reject_edge", lastrej - e0, 7);
      check_output("t4_coin10_none", n10 - b10, 0);
      apply_stimulus(0, 0, 1, 12);
      snapshot(); e0 = edge_no + 1;
      apply_stimulus(0, 1, 1, 12);
      check_output("t4b_coin10_count", n10 - b10, 1);
      check_output("t4b_coin10_edge", last10 - e0, 7);
      check_output("t4b_reject_none", nrej - brej, 0);
      apply_stimulus(0, 0, 1, 12);

      $display("[TB] scenario 5: slot held across reset release");
      apply_stimulus(1, 0, 1, 3);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      snapshot();
      apply_stimulus(1, 0, 1, 10);
      check_output("t5_held_silent", (n5 - b5) + (n10 - b10) + (nrej - brej), 0);
      apply_stimulus(0, 0, 1, 6);
      e0 = edge_no + 1;
      apply_stimulus(1, 0, 1, 12);
      check_output("t5_coin5_count", n5 - b5, 1);
      check_output("t5_coin5_edge", last5 - e0, 7);
      apply_stimulus(0, 0, 1, 12);

      $display("[TB] scenario 6: reset mid-debounce");
      snapshot();
      apply_stimulus(0, 1, 1, 5);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      apply_stimulus(0, 1, 1, 20);
      check_output("t6_dropped", (n5 - b5) + (n10 - b10) + (nrej - brej), 0);
      check_output("t6_outputs_low", int'(bus.coin5) + int'(bus.coin10) + int'(bus.coin_reject), 0);

      check_output("total_value", total_value, 45);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
